// File: rtl/ps2_packet_rx.sv
// PS/2 device-to-host receiver: filters the lines, checks each 11-bit frame and
// assembles PACKET_BYTES-byte packets into a small first-word-fall-through FIFO.
module ps2_packet_rx #(
  parameter int PACKET_BYTES   = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_CHECK     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MOUSE_CLOCK,
  input  logic                      MOUSE_DATA,
  input  logic                      io_cs,
  input  logic                      addr,
  output logic [8*PACKET_BYTES-1:0] data_out,
  output logic                      RDA,
  output logic                      err_irq
);

  localparam int W  = 8*PACKET_BYTES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;

  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PACKET_BYTES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d, fall_q, fall_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          start_err, shift_en, par_en, byte_done;
  logic          stop_bad, par_bad, sync_bad, byte_ok;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout, active;
  logic [IW-1:0] idx_q;
  logic          push_q;
  logic [W-1:0]  pkt_w;
  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop, full, wr_en, ovf_ev, stat_rd;
  logic          parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d, err_irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= MOUSE_CLOCK;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= MOUSE_DATA;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FILT_MAX) filt_d = clk_s2_q;
      else                    fcnt_d = fcnt_q + 1'b1;
    end
  end
  assign fall_d = filt_q & ~filt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= fall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (fall_q) begin
      case (state_q)
        S_IDLE:   if (!dat_s2_q) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_err = fall_q & (state_q == S_IDLE) & dat_s2_q;
    shift_en  = fall_q & (state_q == S_DATA);
    par_en    = fall_q & (state_q == S_PARITY);
    byte_done = fall_q & (state_q == S_STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE) bit_cnt_q <= '0;
      if (shift_en) begin
        shift_q   <= {dat_s2_q, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (par_en) par_q <= dat_s2_q;
    end
  end

  always_comb begin
    stop_bad = byte_done & ~dat_s2_q;
    par_bad  = byte_done & dat_s2_q & ~(^{shift_q, par_q});
    sync_bad = byte_done & dat_s2_q & (^{shift_q, par_q}) & (SYNC_CHECK != 0)
               & (idx_q == '0) & ~shift_q[3];
    byte_ok  = byte_done & dat_s2_q & (^{shift_q, par_q}) & ~sync_bad;
  end

  assign active = (state_q != S_IDLE) || (idx_q != '0);

  always_comb begin
    to_cnt_d = to_cnt_q;
    timeout  = 1'b0;
    if (fall_q || !active) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      timeout  = 1'b1;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      idx_q    <= '0;
      push_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      push_q   <= 1'b0;
      if (timeout || stop_bad || par_bad) begin
        idx_q <= '0;
      end else if (byte_ok) begin
        if (idx_q == IDX_LAST) begin
          idx_q  <= '0;
          push_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PACKET_BYTES; gi++) begin : g_lane
      logic [7:0] lane_q;
      always_ff @(posedge clk) begin
        if (rst)                               lane_q <= '0;
        else if (byte_ok && idx_q == IW'(gi))  lane_q <= shift_q;
      end
      assign pkt_w[8*gi +: 8] = lane_q;
    end
  endgenerate

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  always_comb begin
    pop    = io_cs & ~addr & (count_q != '0);
    full   = (count_q == FULL_CNT);
    wr_en  = push_q & (~full | pop);
    ovf_ev = push_q & full & ~pop;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pkt_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    stat_rd      = io_cs & addr;
    parity_err_d = par_bad | (parity_err_q & ~stat_rd);
    frame_err_d  = start_err | stop_bad | sync_bad | timeout | (frame_err_q & ~stat_rd);
    overflow_d   = ovf_ev | (overflow_q & ~stat_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      err_irq_q    <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      err_irq_q    <= parity_err_d | frame_err_d | overflow_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (io_cs) begin
      if (!addr) begin
        if (count_q != '0) data_out = mem_q[rd_ptr_q];
      end else begin
        data_out[0]       = parity_err_q;
        data_out[1]       = frame_err_q;
        data_out[2]       = overflow_q;
        data_out[3 +: CW] = count_q;
      end
    end
  end

  assign RDA     = (count_q != '0);
  assign err_irq = err_irq_q;

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Directed bench for ps2_packet_rx: bit-bangs PS/2 frames and checks packets,
// status, error recovery and reset against hand-computed values.
module tb_ps2_packet_rx;

  logic        clk = 1'b0;
  logic        rst, ps2c, ps2d, io_cs, addr;
  logic [23:0] data_out;
  logic        rda, err_irq;
  logic [23:0] v;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ps2_packet_rx #(
    .PACKET_BYTES(3), .FIFO_DEPTH(4), .FILTER_LEN(4),
    .TIMEOUT_CYCLES(100), .SYNC_CHECK(1)
  ) dut (
    .clk(clk), .rst(rst), .MOUSE_CLOCK(ps2c), .MOUSE_DATA(ps2d),
    .io_cs(io_cs), .addr(addr), .data_out(data_out), .RDA(rda), .err_irq(err_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One PS/2 bit: data set up while clock high, then a 10-cycle low and high phase.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2d = b;
    repeat (5) @(negedge clk);
    ps2c = 1'b0;
    if (glitch) begin
      repeat (3) @(negedge clk); ps2c = 1'b1;
      repeat (2) @(negedge clk); ps2c = 1'b0;
      repeat (5) @(negedge clk);
    end else repeat (10) @(negedge clk);
    ps2c = 1'b1;
    if (glitch) begin
      repeat (3) @(negedge clk); ps2c = 1'b0;
      repeat (2) @(negedge clk); ps2c = 1'b1;
      repeat (5) @(negedge clk);
    end else repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
  endtask

  task automatic send_packet(input logic [23:0] p);
    send_byte(p[7:0]);
    send_byte(p[15:8]);
    send_byte(p[23:16]);
  endtask

  task automatic cpu_read(input logic a, output logic [23:0] val);
    @(negedge clk);
    io_cs = 1'b1;
    addr  = a;
    #1 val = data_out;
    @(negedge clk);
    io_cs = 1'b0;
    addr  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1; io_cs = 1'b0; addr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rda", rda, 0);
    check("reset_irq", err_irq, 0);
    check("reset_dout", data_out, 0);
    @(negedge clk) rst = 1'b0;
    cpu_read(1'b1, v);
    check("reset_status", v, 24'h000000);

    // Clean packet; RDA must rise exactly two cycles after the last stop-bit strobe
    send_byte(8'h08);
    send_byte(8'h05);
    send_frame(8'hFB, 1'b0, 10, 1'b0);
    ps2d = 1'b1;
    repeat (5) @(negedge clk);
    ps2c = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 7) check("rda_before", rda, 0);
      if (k == 8) check("rda_at_2cyc", rda, 1);
    end
    @(negedge clk);
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (10) @(negedge clk);
    cpu_read(1'b0, v);
    check("pkt1", v, 24'hFB0508);
    check("pkt1_rda_after", rda, 0);

    // Bad parity on byte 1 drops the partial packet
    send_byte(8'h08);
    send_frame(8'h05, 1'b1, 11, 1'b0);
    send_packet(24'h020109);
    check("par_irq", err_irq, 1);
    cpu_read(1'b1, v);
    check("par_status1", v, 24'h000009);
    cpu_read(1'b1, v);
    check("par_status2", v, 24'h000008);
    check("par_irq_clr", err_irq, 0);
    cpu_read(1'b0, v);
    check("par_pkt", v, 24'h020109);

    // Timeout after 5 bits of the second byte
    send_byte(8'h08);
    send_frame(8'h3C, 1'b0, 5, 1'b0);
    repeat (150) @(negedge clk);
    check("to_irq", err_irq, 1);
    cpu_read(1'b1, v);
    check("to_status", v, 24'h000002);
    send_packet(24'h22110A);
    cpu_read(1'b0, v);
    check("to_pkt", v, 24'h22110A);
    check("to_rda", rda, 0);

    // Overflow: five packets into a four-entry FIFO
    for (int i = 0; i < 5; i++)
      send_packet({8'h40 + 8'(i), 8'h20 + 8'(i), 8'h08 + 8'(i)});
    cpu_read(1'b1, v);
    check("ovf_status", v, 24'h000024);
    for (int i = 0; i < 4; i++) begin
      cpu_read(1'b0, v);
      check($sformatf("ovf_pkt%0d", i), v, {8'h40 + 8'(i), 8'h20 + 8'(i), 8'h08 + 8'(i)});
    end
    check("ovf_rda", rda, 0);

    // Clock glitches mid-frame, then a sync-check failure on byte 0
    send_frame(8'h0D, 1'b0, 11, 1'b1);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h00);
    cpu_read(1'b1, v);
    check("sync_status", v, 24'h00000A);
    cpu_read(1'b0, v);
    check("glitch_pkt", v, 24'hA55A0D);
    send_packet(24'h44330B);
    cpu_read(1'b1, v);
    check("sync_next_status", v, 24'h000008);
    send_byte(8'h00);
    check("sync_irq", err_irq, 1);

    // Reset in the middle of the second byte
    send_byte(8'h08);
    send_frame(8'h77, 1'b0, 4, 1'b0);
    @(negedge clk);
    rst = 1'b1; io_cs = 1'b1; addr = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rda", rda, 0);
    check("rst_irq", err_irq, 0);
    check("rst_status", data_out, 24'h000000);
    @(negedge clk);
    rst = 1'b0; io_cs = 1'b0; addr = 1'b0;
    send_packet(24'h81700F);
    cpu_read(1'b0, v);
    check("rst_pkt", v, 24'h81700F);
    check("rst_rda_after", rda, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_packet_rx.md
Name: ps2_packet_rx

Overview:
Parametrised receive-only PS/2 device-to-host deserialiser and packet assembler. It is the successor to the fixed 3-byte ps2_mouse receive path.
- Filters and synchronises the PS/2 clock and data lines.
- Checks start, odd-parity and stop bits on every frame.
- Assembles PACKET_BYTES-byte packets into a first-word-fall-through FIFO.
- The CPU reads the FIFO through the io_cs/addr port.
- Adds three capabilities: configurable packet length, a packet FIFO, and error/timeout recovery.

Parameters:
PACKET_BYTES, 3, bytes per packet (1..4); data word width is 8*PACKET_BYTES.
FIFO_DEPTH, 4, packet FIFO entries; power of 2, at least 2.
FILTER_LEN, 4, consecutive identical samples needed before the filtered PS/2 clock changes.
TIMEOUT_CYCLES, 20000, maximum clk cycles between falling edges inside a frame or packet.
SYNC_CHECK, 1, when 1, byte 0 of every packet must have bit 3 = 1.

Ports:
clk  in  1  system clock; only clock domain.
rst  in  1  synchronous reset, active-high.
MOUSE_CLOCK  in  1  PS/2 clock line, asynchronous.
MOUSE_DATA  in  1  PS/2 data line, asynchronous.
io_cs  in  1  CPU select.
addr  in  1  register select: 0 = packet FIFO head, 1 = status.
data_out  out  8*PACKET_BYTES  read data (see Behaviour).
RDA  out  1  FIFO not empty.
err_irq  out  1  OR of the sticky error flags.

Behaviour:
Reset (rst sampled high at a clk edge):
- FSM goes to IDLE.
- FIFO is emptied; byte index is 0.
- Sticky flags parity_err, frame_err and overflow are cleared; timeout counter is cleared.
- Synchroniser and filter registers are set to 1 (idle line).
- Outputs: RDA=0, err_irq=0, data_out=0.
- Reset mid-frame discards the partial byte and the partial packet.

Input path and edge detection:
- Each line passes through a 2-FF synchroniser.
- Filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
- A falling edge of the filtered clock produces a 1-cycle fall strobe.
- Data is sampled on the fall strobe.

Frame FSM (one state per step):
- IDLE: on fall with data=0 (start bit), go to DATA. On fall with data=1, stay in IDLE and set frame_err.
- DATA: shift 8 bits, LSB first. After the 8th bit, go to PARITY.
- PARITY: capture the parity bit, go to STOP. Parity is odd: the 8 data bits plus the parity bit contain an odd number of 1s.
- STOP: on fall, the byte is complete. Return to IDLE.

Byte handling at byte completion:
- If stop bit = 0: set frame_err and discard the byte.
- Else if parity is bad: set parity_err and discard the byte.
- In both error cases the partial packet is dropped and the byte index resets to 0.
- SYNC_CHECK=1 with byte index 0 and bit3=0: drop the byte, set frame_err, index stays 0.
- Otherwise byte k is written to packet bits [8k+7:8k] and the index increments.

Timeout:
- The counter runs while the FSM is not IDLE, or while the byte index is nonzero.
- It clears on every fall strobe.
- When it reaches TIMEOUT_CYCLES: FSM goes to IDLE, the byte index goes to 0, and frame_err is set.

Packet push:
- The push happens in the cycle after the stop-bit strobe of byte PACKET_BYTES-1.
- RDA rises the cycle after the push if the FIFO was empty, i.e. 2 clk cycles after the strobe.
- FIFO full at push time with no simultaneous pop: the packet is dropped, overflow is set, and FIFO contents are unchanged.
- Push and pop in the same cycle: both take effect, including when the FIFO is full; overflow is not set.

CPU read (combinational data_out):
- io_cs=0: data_out = 0.
- io_cs=1, addr=0: data_out = FIFO head, or 0 if the FIFO is empty. Pops one entry at the clk edge, only if not empty. A pop on an empty FIFO is ignored.
- io_cs=1, addr=1: data_out bit0 = parity_err, bit1 = frame_err, bit2 = overflow. Bits [3+CW-1:3] = FIFO count, where CW = clog2(FIFO_DEPTH)+1. Remaining bits are 0.
- A status read clears all three sticky flags at the clk edge. An error event in the same cycle wins: its flag stays 1.
- io_cs is a 1-cycle strobe per access; each asserted cycle counts as one access.
- err_irq = parity_err | frame_err | overflow, registered.

Test Plan:
- Reset, then send bytes 0x08, 0x05, 0xFB with correct parity (FILTER_LEN=4) → RDA=1 exactly 2 cycles after the 3rd stop-bit strobe. Read addr=0 returns 24'hFB0508, then RDA=0.
- Bad parity on byte 1 of a packet, followed by a clean packet 0x09,0x01,0x02 → only 24'h020109 is queued. Status read returns bit0=1 with count=1; a second status read returns bit0=0.
- Stop after 5 bits of a byte for more than TIMEOUT_CYCLES (set to 100) → frame_err=1 and err_irq=1. The next clean packet is received correctly.
- Send FIFO_DEPTH+1 packets with no reads → overflow=1 and count=FIFO_DEPTH. The first FIFO_DEPTH packets read back in order; the extra packet is absent.
- Glitches on MOUSE_CLOCK shorter than FILTER_LEN cycles mid-frame → no extra bits captured, byte value intact. SYNC_CHECK byte 0x00 as the first byte → dropped, frame_err=1.
- Assert rst in the middle of the second byte → all outputs are 0 next cycle. A following full packet is assembled from byte 0.
